axis_rr_arbiter: RTL and testbench
==================================

Name: axis_rr_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one downstream AXI-Stream slave among NUM_SRC upstream AXI-Stream masters, such as the 4-beat packet generators used in this design.
- Once a source is granted, the block holds the grant for that source's whole packet, up to and including the beat that carries tlast. Only then does it re-arbitrate.
- Also enforces a maximum packet length and reports per-packet status.

Parameters:
- NUM_SRC, 4, number of upstream sources (2..8).
- DATA_W, 8, tdata width in bits.
- MAX_BEATS, 16, maximum beats per packet before forced termination (2..255).
- ID_W, 2, width of the source-id output; must equal clog2(NUM_SRC).

Ports:
- m_axis_aclk  in  1  single clock for all logic.
- m_axis_aresetn  in  1  asynchronous active-low reset.
- s_axis_tvalid  in  NUM_SRC  per-source valid.
- s_axis_tdata  in  NUM_SRC*DATA_W  per-source data; source i occupies bits [i*DATA_W +: DATA_W].
- s_axis_tlast  in  NUM_SRC  per-source last.
- s_axis_tready  out  NUM_SRC  per-source ready.
- m_axis_tready  in  1  downstream ready.
- m_axis_tvalid  out  1  downstream valid.
- m_axis_tdata  out  DATA_W  downstream data.
- m_axis_tlast  out  1  downstream last.
- m_axis_tid  out  ID_W  index of the granted source; valid whenever m_axis_tvalid=1.
- pkt_done  out  1  one-cycle pulse when a packet's final beat is accepted downstream.
- pkt_trunc  out  1  one-cycle pulse, coincident with pkt_done, when the packet was force-terminated.

Behaviour:
- Reset: asynchronous and active-low; the clock is m_axis_aclk and the reset is m_axis_aresetn, asserted asynchronously and released synchronously to the clock inside the block.
  - On reset: state=IDLE, grant=0, rr_ptr=0, beat_cnt=0.
  - Outputs during reset: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tid=0, s_axis_tready=0, pkt_done=0, pkt_trunc=0.
- Reset mid-packet drops the packet, with no completion pulse. The sources are responsible for restarting it.
- FSM, two states:
  - IDLE: all s_axis_tready=0 and m_axis_tvalid=0. If any s_axis_tvalid is high, grant is registered to the first valid index searching rr_ptr, rr_ptr+1, ... modulo NUM_SRC. The FSM then enters BUSY. If no source is valid, it stays in IDLE.
  - BUSY: the granted source is combinationally muxed to the downstream port:
    - m_axis_tvalid = s_axis_tvalid[grant].
    - m_axis_tdata = that source's data when m_axis_tvalid=1, else 0.
    - s_axis_tready[grant] = m_axis_tready; every other tready bit = 0.
    - m_axis_tid = grant.
- Arbitration latency is exactly 1 cycle from IDLE sampling a valid to the first BUSY cycle. Data then passes with zero latency, because there is no storage in the path.
- Beat accept: the cycle in which m_axis_tvalid && m_axis_tready is high. beat_cnt increments on each accepted beat.
- m_axis_tlast = s_axis_tlast[grant] OR (beat_cnt == MAX_BEATS-1), gated by m_axis_tvalid.
- End of packet: an accepted beat with m_axis_tlast=1.
  - Registered effects: pkt_done=1 for one cycle, and pkt_trunc=1 for the same cycle if the source's tlast was 0.
  - State updates: beat_cnt=0, rr_ptr=(grant+1) mod NUM_SRC, state returns to IDLE.
  - pkt_done and pkt_trunc are asserted in the cycle after the accepting edge.
  - There is always at least one idle cycle between packets.
- After truncation, any remaining beats of that source's packet are treated as a new packet in later arbitration.
- Valid drop inside a packet: s_axis_tvalid[grant] falling to 0 in BUSY keeps the grant. m_axis_tvalid follows it to 0, and there is no timeout.
- Valid changes in non-granted sources during BUSY have no effect.
- Fairness: with all sources continuously valid, grants rotate 0,1,2,...,NUM_SRC-1,0. No source waits more than NUM_SRC-1 packets.
- Single-beat packet (tlast on the first beat) completes in one BUSY cycle if ready is high.
- Backpressure: m_axis_tready=0 holds the selected beat. tdata and tlast must remain stable, as guaranteed by the AXIS source rules.

Test Plan:
- Reset: hold aresetn=0 with all sources valid → all outputs 0. Assert aresetn=0 mid-packet at beat 2 → the next cycle shows m_axis_tvalid=0, no pkt_done, and rr_ptr=0, so source 0 is granted first after release.
- Single source: source 2 sends 4 beats of data 0x05,0x0A,0x0F,0x14 with tlast on beat 4 and tready=1 → m_axis_tid=2, data appears with zero latency, m_axis_tlast on the 4th beat, pkt_done pulses once, pkt_trunc=0.
- Round-robin: all 4 sources continuously valid with 2-beat packets → grant order 0,1,2,3,0,1, with one IDLE cycle between packets. Non-granted tready stays 0 throughout.
- Backpressure: source 1 packet, m_axis_tready toggles 1,0,0,1,1 → exactly 4 beats are accepted with no duplication or loss. s_axis_tready[1] mirrors m_axis_tready.
- Truncation: MAX_BEATS=16, source 3 streams 20 beats with no tlast → m_axis_tlast on beat 16, and pkt_done=pkt_trunc=1. Beats 17-20 arrive as a new 4-beat packet after re-arbitration.
- Skip idle sources: only sources 0 and 3 valid, rr_ptr=1 → source 3 is granted, then source 0.

Source files
------------

// File: rtl/axis_rr_arbiter_if.sv
// AXI-Stream bundle for the round-robin arbiter: NUM_SRC upstream streams plus one downstream stream.
// "master" is the arbiter's view (it masters the downstream stream); "slave" is the surrounding logic.
interface axis_rr_arbiter_if #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = 2
);
  logic [NUM_SRC-1:0]        s_axis_tvalid;
  logic [NUM_SRC*DATA_W-1:0] s_axis_tdata;
  logic [NUM_SRC-1:0]        s_axis_tlast;
  logic [NUM_SRC-1:0]        s_axis_tready;
  logic                      m_axis_tready;
  logic                      m_axis_tvalid;
  logic [DATA_W-1:0]         m_axis_tdata;
  logic                      m_axis_tlast;
  logic [ID_W-1:0]           m_axis_tid;

  modport master (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tid
  );

  modport slave (
    output s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tid
  );
endinterface

// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin arbiter: one cycle to grant, then zero-latency mux of the granted
// source until tlast or the MAX_BEATS cap; downstream tready is passed straight to the granted source.
module axis_rr_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = 16,
  parameter int ID_W      = 2
) (
  input  logic              m_axis_aclk,
  input  logic              m_axis_aresetn,
  axis_rr_arbiter_if.master bus,
  output logic              pkt_done,
  output logic              pkt_trunc
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t            state, state_nx;
  logic [ID_W-1:0]   grant, grant_nx;
  logic [ID_W-1:0]   rr_ptr, rr_ptr_nx;
  logic [7:0]        beat_cnt, beat_cnt_nx;
  logic              done_nx, trunc_nx;
  logic [1:0]        rst_sync;
  logic              rst_n;
  logic              found;
  logic [ID_W-1:0]   pick, cand;
  logic              src_vld, src_last;
  logic [DATA_W-1:0] src_dat;
  logic              out_vld, out_last, accept;

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) rst_sync <= '0;
    else                 rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  always_ff @(posedge m_axis_aclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      beat_cnt  <= '0;
      pkt_done  <= 1'b0;
      pkt_trunc <= 1'b0;
    end else begin
      state     <= state_nx;
      grant     <= grant_nx;
      rr_ptr    <= rr_ptr_nx;
      beat_cnt  <= beat_cnt_nx;
      pkt_done  <= done_nx;
      pkt_trunc <= trunc_nx;
    end
  end

  always_comb begin
    found    = 1'b0;
    pick     = '0;
    cand     = '0;
    src_vld  = 1'b0;
    src_last = 1'b0;
    src_dat  = '0;
    bus.s_axis_tready = '0;
    bus.m_axis_tvalid = 1'b0;
    bus.m_axis_tdata  = '0;
    bus.m_axis_tlast  = 1'b0;
    bus.m_axis_tid    = '0;
    state_nx    = state;
    grant_nx    = grant;
    rr_ptr_nx   = rr_ptr;
    beat_cnt_nx = beat_cnt;
    done_nx     = 1'b0;
    trunc_nx    = 1'b0;

    // First valid source at or after rr_ptr, wrapping.
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % NUM_SRC);
      if (!found && bus.s_axis_tvalid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end

    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant == ID_W'(i)) begin
        src_vld  = bus.s_axis_tvalid[i];
        src_last = bus.s_axis_tlast[i];
        src_dat  = bus.s_axis_tdata[i*DATA_W +: DATA_W];
      end
    end

    out_vld  = (state == BUSY) && src_vld;
    out_last = out_vld && (src_last || (beat_cnt == 8'(MAX_BEATS - 1)));
    accept   = out_vld && bus.m_axis_tready;

    if (state == BUSY) begin
      bus.m_axis_tvalid = out_vld;
      bus.m_axis_tdata  = out_vld ? src_dat : '0;
      bus.m_axis_tlast  = out_last;
      bus.m_axis_tid    = grant;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (grant == ID_W'(i)) bus.s_axis_tready[i] = bus.m_axis_tready;
      end
    end

    case (state)
      IDLE: begin
        if (found) begin
          grant_nx = pick;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (accept) begin
          if (out_last) begin
            // A cap-forced last is a truncation; leftover beats re-arbitrate as a new packet.
            done_nx     = 1'b1;
            trunc_nx    = !src_last;
            beat_cnt_nx = '0;
            rr_ptr_nx   = (grant == ID_W'(NUM_SRC - 1)) ? '0 : grant + ID_W'(1);
            state_nx    = IDLE;
          end else begin
            beat_cnt_nx = beat_cnt + 8'd1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Bench for axis_rr_arbiter: queued per-source streams, a packet-level reference model compared
// every cycle, end-to-end stream checks and literal expectations for the directed scenarios.
module tb_axis_rr_arbiter;
  localparam int NS    = 4;
  localparam int DW    = 8;
  localparam int MAXB  = 16;
  localparam int IW    = 2;
  localparam int DEPTH = 2048;

  logic clk;
  logic arst_n;
  logic pkt_done, pkt_trunc;

  axis_rr_arbiter_if #(.NUM_SRC(NS), .DATA_W(DW), .ID_W(IW)) bus ();

  axis_rr_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .MAX_BEATS(MAXB), .ID_W(IW)) dut (
    .m_axis_aclk    (clk),
    .m_axis_aresetn (arst_n),
    .bus            (bus),
    .pkt_done       (pkt_done),
    .pkt_trunc      (pkt_trunc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] q_dat  [NS][DEPTH];
  logic          q_last [NS][DEPTH];
  int            head [NS];
  int            tail [NS];
  logic [DW-1:0] rx_dat [NS][DEPTH];
  int            rx_n [NS];
  int            log_src[$];
  int            log_beats[$];
  int            log_trunc[$];
  int            done_cnt = 0;
  int            trunc_cnt = 0;

  // Reference model: who owns the output, next search start, beats so far, pending pulses.
  bit m_busy = 0;
  int m_own = 0, m_ptr = 0, m_cnt = 0, m_rcnt = 0;
  bit m_done = 0, m_trunc = 0;

  int            p_vld = 100;
  int            p_rdy = 100;
  bit            pat[$];
  logic [NS-1:0] rdy_smp;
  logic [17:0]   dut_vec, exp_vec;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [17:0] model_outs();
    logic v, l;
    logic [DW-1:0] d;
    logic [NS-1:0] r;
    logic [IW-1:0] id;
    v = 1'b0; l = 1'b0; d = '0; r = '0; id = '0;
    if (arst_n && m_busy) begin
      v  = bus.s_axis_tvalid[m_own];
      d  = v ? bus.s_axis_tdata[m_own*DW +: DW] : '0;
      l  = v && (bus.s_axis_tlast[m_own] || (m_cnt == MAXB - 1));
      id = IW'(m_own);
      r[m_own] = bus.m_axis_tready;
    end
    return {v, d, l, id, r, arst_n & m_done, arst_n & m_trunc};
  endfunction

  task automatic model_step();
    bit got;
    m_done  = 0;
    m_trunc = 0;
    if (!arst_n) begin
      m_rcnt = 0; m_busy = 0; m_ptr = 0; m_cnt = 0;
    end else if (m_rcnt < 2) begin
      m_rcnt++;
    end else if (!m_busy) begin
      got = 0;
      for (int k = 0; k < NS; k++) begin
        if (!got && bus.s_axis_tvalid[(m_ptr + k) % NS]) begin
          got    = 1;
          m_own  = (m_ptr + k) % NS;
          m_busy = 1;
        end
      end
    end else if (bus.s_axis_tvalid[m_own] && bus.m_axis_tready) begin
      if (bus.s_axis_tlast[m_own] || (m_cnt == MAXB - 1)) begin
        log_src.push_back(m_own);
        log_beats.push_back(m_cnt + 1);
        log_trunc.push_back(bus.s_axis_tlast[m_own] ? 0 : 1);
        m_done  = 1;
        m_trunc = !bus.s_axis_tlast[m_own];
        m_ptr   = (m_own + 1) % NS;
        m_cnt   = 0;
        m_busy  = 0;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic drive();
    bit popped, held, v;
    for (int i = 0; i < NS; i++) begin
      popped = bus.s_axis_tvalid[i] && rdy_smp[i];
      held   = bus.s_axis_tvalid[i] && !popped;
      v      = (head[i] < tail[i]) && (held || ($urandom_range(0, 99) < p_vld));
      bus.s_axis_tvalid[i] = v;
      bus.s_axis_tdata[i*DW +: DW] = (head[i] < tail[i]) ? q_dat[i][head[i]] : '0;
      bus.s_axis_tlast[i] = (head[i] < tail[i]) ? q_last[i][head[i]] : 1'b0;
    end
    if (m_busy && pat.size() > 0) bus.m_axis_tready = pat.pop_front();
    else bus.m_axis_tready = ($urandom_range(0, 99) < p_rdy);
  endtask

  task automatic tick();
    int t;
    @(negedge clk);
    dut_vec = {bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tid,
               bus.s_axis_tready, pkt_done, pkt_trunc};
    exp_vec = model_outs();
    chk("cycle_outputs", 32'(dut_vec), 32'(exp_vec));
    rdy_smp = bus.s_axis_tready;
    if (pkt_done) done_cnt++;
    if (pkt_trunc) trunc_cnt++;
    if (bus.m_axis_tvalid && bus.m_axis_tready) begin
      t = int'(bus.m_axis_tid);
      if (rx_n[t] < DEPTH) begin
        rx_dat[t][rx_n[t]] = bus.m_axis_tdata;
        rx_n[t]++;
      end
    end
    @(posedge clk);
    model_step();
    for (int i = 0; i < NS; i++)
      if (bus.s_axis_tvalid[i] && rdy_smp[i]) head[i]++;
    #1;
    drive();
  endtask

  task automatic push_beat(input int s, input logic [DW-1:0] d, input logic l);
    q_dat[s][tail[s]]  = d;
    q_last[s][tail[s]] = l;
    tail[s]++;
  endtask

  task automatic clear_phase();
    for (int i = 0; i < NS; i++) begin
      head[i] = 0; tail[i] = 0; rx_n[i] = 0;
    end
    log_src.delete(); log_beats.delete(); log_trunc.delete();
    done_cnt = 0; trunc_cnt = 0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    bit busy;
    n = 0;
    do begin
      tick();
      n++;
      busy = m_busy || m_done;
      for (int i = 0; i < NS; i++) if (head[i] < tail[i]) busy = 1;
    end while (busy && n < budget);
    chk({name, "_drain_timeout"}, 32'(busy), 0);
  endtask

  task automatic e2e(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < NS; i++) begin
      if (rx_n[i] != tail[i]) bad++;
      else for (int j = 0; j < tail[i]; j++) if (rx_dat[i][j] !== q_dat[i][j]) bad++;
    end
    chk({name, "_stream"}, 32'(bad), 0);
  endtask

  function automatic int qget(input int q[$], input int k);
    return (k < q.size()) ? q[k] : -1;
  endfunction

  int            rr_exp[6] = '{0, 1, 2, 3, 0, 1};
  logic [DW-1:0] sgl_exp[4] = '{8'h05, 8'h0A, 8'h0F, 8'h14};
  int            n, len;

  initial begin
    arst_n = 1'b0;
    bus.s_axis_tvalid = '0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tlast  = '0;
    bus.m_axis_tready = 1'b0;
    rdy_smp = '0;
    clear_phase();

    // Reset held with every source offering a one-beat packet.
    for (int i = 0; i < NS; i++) push_beat(i, 8'(8'h10 + i), 1'b1);
    repeat (4) tick();
    chk("reset_outputs_zero", 32'(dut_vec), 0);
    arst_n = 1'b1;
    wait_drain("reset_release", 200);
    chk("reset_pkt_count", 32'(log_src.size()), 4);
    for (int k = 0; k < 4; k++) chk("reset_grant_order", 32'(qget(log_src, k)), 32'(k));
    chk("reset_done_pulses", 32'(done_cnt), 4);
    e2e("reset_release");

    // Round robin: two 2-beat packets per source, all continuously offered.
    clear_phase();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NS; i++)
        for (int b = 0; b < 2; b++) push_beat(i, 8'(i*16 + r*2 + b), 1'(b == 1));
    wait_drain("rr", 400);
    for (int k = 0; k < 6; k++) chk("rr_grant_order", 32'(qget(log_src, k)), 32'(rr_exp[k]));
    chk("rr_done_pulses", 32'(done_cnt), 8);
    e2e("rr");

    // Skip idle sources: after a source-0 packet the pointer sits at 1, so 3 wins over 0.
    clear_phase();
    push_beat(0, 8'h31, 1'b0); push_beat(0, 8'h32, 1'b1);
    wait_drain("skip_pre", 100);
    clear_phase();
    push_beat(0, 8'h41, 1'b0); push_beat(0, 8'h42, 1'b1);
    push_beat(3, 8'h71, 1'b0); push_beat(3, 8'h72, 1'b1);
    wait_drain("skip", 100);
    chk("skip_first_grant", 32'(qget(log_src, 0)), 3);
    chk("skip_second_grant", 32'(qget(log_src, 1)), 0);
    e2e("skip");

    // Single source, four beats.
    clear_phase();
    for (int b = 0; b < 4; b++) push_beat(2, sgl_exp[b], 1'(b == 3));
    wait_drain("single", 100);
    chk("single_src", 32'(qget(log_src, 0)), 2);
    chk("single_beats", 32'(qget(log_beats, 0)), 4);
    chk("single_trunc", 32'(qget(log_trunc, 0)), 0);
    chk("single_done_pulses", 32'(done_cnt), 1);
    chk("single_trunc_pulses", 32'(trunc_cnt), 0);
    chk("single_rx_count", 32'(rx_n[2]), 4);
    for (int b = 0; b < 4; b++) chk("single_rx_data", 32'(rx_dat[2][b]), 32'(sgl_exp[b]));

    // Backpressure on a source-1 packet: ready 1,0,0,1,1 then held high.
    clear_phase();
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int b = 0; b < 4; b++) push_beat(1, 8'(8'hA0 + b), 1'(b == 3));
    wait_drain("bp", 100);
    pat.delete();
    chk("bp_rx_count", 32'(rx_n[1]), 4);
    chk("bp_done_pulses", 32'(done_cnt), 1);
    e2e("bp");

    // Reset after the second beat of a packet; pointer must return to source 0.
    clear_phase();
    for (int b = 0; b < 4; b++) push_beat(1, 8'(8'hB0 + b), 1'(b == 3));
    n = 0;
    while (rx_n[1] < 2 && n < 100) begin tick(); n++; end
    chk("midrst_reached_beat2", 32'(rx_n[1] >= 2), 1);
    arst_n = 1'b0;
    tick();
    chk("midrst_tvalid", 32'(dut_vec[17]), 0);
    chk("midrst_no_done", 32'(dut_vec[1]), 0);
    clear_phase();
    for (int i = 0; i < NS; i++) push_beat(i, 8'(8'hC0 + i), 1'b1);
    repeat (2) tick();
    arst_n = 1'b1;
    wait_drain("midrst", 200);
    chk("midrst_first_grant", 32'(qget(log_src, 0)), 0);
    chk("midrst_done_pulses", 32'(done_cnt), 4);
    e2e("midrst");

    // Truncation: 20 beats from source 3, tlast only on beat 20.
    clear_phase();
    for (int b = 0; b < 20; b++) push_beat(3, 8'(b + 1), 1'(b == 19));
    wait_drain("trunc", 200);
    chk("trunc_pkt_count", 32'(log_src.size()), 2);
    chk("trunc_first_beats", 32'(qget(log_beats, 0)), 16);
    chk("trunc_first_flag", 32'(qget(log_trunc, 0)), 1);
    chk("trunc_second_src", 32'(qget(log_src, 1)), 3);
    chk("trunc_second_beats", 32'(qget(log_beats, 1)), 4);
    chk("trunc_second_flag", 32'(qget(log_trunc, 1)), 0);
    chk("trunc_done_pulses", 32'(done_cnt), 2);
    chk("trunc_trunc_pulses", 32'(trunc_cnt), 1);
    e2e("trunc");

    // Random traffic with valid gaps between beats and random downstream ready.
    clear_phase();
    p_vld = 60;
    p_rdy = 70;
    for (int i = 0; i < NS; i++)
      for (int p = 0; p < 6; p++) begin
        len = int'($urandom_range(1, 20));
        for (int b = 0; b < len; b++) push_beat(i, 8'($urandom), 1'(b == len - 1));
      end
    wait_drain("random", 6000);
    chk("random_done_vs_model", 32'(done_cnt), 32'(log_src.size()));
    e2e("random");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
